// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryptor, ROUNDS_PER_CYCLE unrolled rounds per busy cycle.
// Define AES_CTR_MODE_EN for counter mode (adds iv/iv_load ports).
module aes128_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
`ifdef AES_CTR_MODE_EN
  ,
  input  logic [127:0] iv,
  input  logic         iv_load
`endif
);
  localparam int ITER = 10 / ROUNDS_PER_CYCLE;
  localparam logic [3:0] RS = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] LAMBDA = 4'h8;
  if (ROUNDS_PER_CYCLE < 1 || ITER * ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
  // GF((2^4)^2) element {h,l} = h*y + l with y^2 = y + LAMBDA
  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction
  function automatic logic [7:0] gf8_inv(input logic [7:0] c);
    logic [3:0] h, l, d, d2, d4, d8, di;
    h = c[7:4];
    l = c[3:0];
    d = gf4_mul(gf4_mul(h, h), LAMBDA) ^ gf4_mul(h, l) ^ gf4_mul(l, l);
    d2 = gf4_mul(d, d);
    d4 = gf4_mul(d2, d2);
    d8 = gf4_mul(d4, d4);
    di = gf4_mul(gf4_mul(d8, d4), d2);
    return {gf4_mul(h, di), gf4_mul(h ^ l, di)};
  endfunction
  function automatic logic [7:0] lin_map(input logic [7:0] x, input logic [63:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = x[i] ? r ^ m[8*i +: 8] : r;
    return r;
  endfunction
  // Basis change: powers of a composite-field root of the AES polynomial, found at elaboration.
  function automatic logic [63:0] iso_fwd();
    logic [63:0] m, res;
    logic [7:0] p, acc;
    logic [8:0] poly;
    logic found;
    res = '0;
    found = 1'b0;
    poly = 9'h11b;
    for (int c = 2; c < 256; c++) begin
      p = 8'h01;
      acc = '0;
      m = '0;
      for (int i = 0; i < 9; i++) begin
        if (i < 8) m[8*i +: 8] = p;
        acc = poly[i] ? acc ^ p : acc;
        p = gf8_mul(p, c[7:0]);
      end
      if (!found && acc == 8'h00) begin
        res = m;
        found = 1'b1;
      end
    end
    return res;
  endfunction
  function automatic logic [63:0] iso_inv(input logic [63:0] m);
    logic [63:0] mi;
    logic [7:0] v;
    mi = '0;
    for (int a = 0; a < 256; a++) begin
      v = lin_map(a[7:0], m);
      for (int j = 0; j < 8; j++) if (v == 8'(1 << j)) mi[8*j +: 8] = a[7:0];
    end
    return mi;
  endfunction
  localparam logic [63:0] FWD = iso_fwd();
  localparam logic [63:0] INV = iso_inv(FWD);
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = lin_map(gf8_inv(lin_map(a, FWD)), INV);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return r == 4'd9 ? 8'h1b : r == 4'd10 ? 8'h36 : 8'h01 << (r - 4'd1);
  endfunction
  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] t, w0, w1, w2, w3;
    t = {sbox(k[23:16]) ^ rcon(r), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
  fsm_t fsm_q, fsm_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, data_out_q, data_out_d;
  logic [127:0] chain_st, chain_rk, src, result;
  logic [3:0] rnd_q, rnd_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, accept;
`ifdef AES_CTR_MODE_EN
  logic [127:0] ctr_q, ctr_d, side_q, side_d;
  assign accept = in_valid & ~iv_load;
  assign src = ctr_q;
  assign result = chain_st ^ side_q;
`else
  assign accept = in_valid;
  assign src = data_in;
  assign result = chain_st;
`endif
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out = data_out_q;
  always_comb begin
    chain_st = st_q;
    chain_rk = rk_q;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      chain_rk = key_next(chain_rk, rnd_q + 4'(i));
      chain_st = sub_shift(chain_st);
      chain_st = ((rnd_q + 4'(i)) == 4'd10 ? chain_st : mix_cols(chain_st)) ^ chain_rk;
    end
  end
  always_comb begin
    fsm_d = fsm_q;
    st_d = st_q;
    rk_d = rk_q;
    rnd_d = rnd_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    data_out_d = data_out_q;
`ifdef AES_CTR_MODE_EN
    ctr_d = ctr_q;
    side_d = side_q;
    if (fsm_q == IDLE && iv_load) ctr_d = iv;
    if (fsm_q == IDLE && accept) begin
      ctr_d = ctr_q + 128'd1;
      side_d = data_in;
    end
`endif
    case (fsm_q)
      IDLE: if (accept) begin
        st_d = src ^ key;
        rk_d = key;
        rnd_d = 4'd1;
        in_ready_d = 1'b0;
        fsm_d = BUSY;
      end
      BUSY: begin
        st_d = chain_st;
        rk_d = chain_rk;
        rnd_d = rnd_q + RS;
        if (rnd_q + RS == 4'd11) begin
          fsm_d = DONE;
          out_valid_d = 1'b1;
          data_out_d = result;
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d = 1'b1;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fsm_q <= IDLE;
      st_q <= '0;
      rk_q <= '0;
      rnd_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q <= '0;
`ifdef AES_CTR_MODE_EN
      ctr_q <= '0;
      side_q <= '0;
`endif
    end else if (en) begin
      fsm_q <= fsm_d;
      st_q <= st_d;
      rk_q <= rk_d;
      rnd_q <= rnd_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_out_q <= data_out_d;
`ifdef AES_CTR_MODE_EN
      ctr_q <= ctr_d;
      side_q <= side_d;
`endif
    end
  end
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb_aes128_iter_core: directed FIPS-197 vectors, handshake, enable and reset checks.
module tb_aes128_iter_core;
  localparam int R = 1;
  localparam int ITER = 10 / R;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] ONES_CT = 128'h3f5b8cc9ea855a0afa7347d23e8d664e;
  function automatic int rpc(input int k);
    return k == 0 ? 2 : k == 1 ? 5 : 10;
  endfunction
  logic clk, clr, en, in_valid, in_ready, out_valid, out_ready, x_ready;
  logic [127:0] data_in, key, data_out;
  logic [2:0] xv, xr;
  logic [127:0] xd [3];
`ifdef AES_CTR_MODE_EN
  logic [127:0] iv;
  logic iv_load;
`endif
  int tests, fails, n, lat, cnt, seen, bad_v, bad_d, bad_r;
  int xlat [3];
  int t [3];
  aes128_iter_core #(.ROUNDS_PER_CYCLE(R)) dut (
    .clk(clk), .clr(clr), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out)
`ifdef AES_CTR_MODE_EN
    , .iv(iv), .iv_load(iv_load)
`endif
  );
  for (genvar g = 0; g < 3; g++) begin : g_x
    aes128_iter_core #(.ROUNDS_PER_CYCLE(rpc(g))) xdut (
      .clk(clk), .clr(clr), .en(en), .in_valid(in_valid), .in_ready(xr[g]),
      .data_in(data_in), .key(key), .out_valid(xv[g]), .out_ready(x_ready),
      .data_out(xd[g])
`ifdef AES_CTR_MODE_EN
      , .iv(iv), .iv_load(iv_load)
`endif
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [127:0] d, input logic [127:0] k);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    data_in = d;
    key = k;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int m);
    m = 0;
    while (!out_valid && m < 60) begin
      @(posedge clk);
      #1;
      m++;
    end
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    clr = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_ready = 1'b1;
    data_in = '0;
    key = '0;
`ifdef AES_CTR_MODE_EN
    iv = '0;
    iv_load = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_data", data_out, 128'(0));
    clr = 1'b0;
    #1;
    check("rst_ready", 128'(in_ready), 128'(1));
`ifdef AES_CTR_MODE_EN
    iv = '1;
    iv_load = 1'b1;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
    send('0, '0);
    wait_out(n);
    check("ctr_lat0", 128'(n), 128'(ITER));
    check("ctr_blk0", data_out, ONES_CT);
    release_out();
    send('0, '0);
    wait_out(n);
    check("ctr_lat1", 128'(n), 128'(ITER));
    check("ctr_blk1_wrap", data_out, Z_CT);
    release_out();
`else
    send(C1_PT, C1_KEY);
    lat = 0;
    for (int k = 0; k < 3; k++) xlat[k] = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (out_valid && lat == 0) lat = e;
      for (int k = 0; k < 3; k++) if (xv[k] && xlat[k] == 0) xlat[k] = e;
    end
    check("c1_lat", 128'(lat), 128'(ITER));
    check("c1_data", data_out, C1_CT);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("c1_r%0d_lat", rpc(k)), 128'(xlat[k]), 128'(10 / rpc(k)));
      check($sformatf("c1_r%0d_data", rpc(k)), xd[k], C1_CT);
    end
    check("c1_ready_low", 128'(in_ready), 128'(0));
    release_out();
    check("c1_drop", 128'(out_valid), 128'(0));
    check("c1_ready_back", 128'(in_ready), 128'(1));
    check("c1_hold_data", data_out, C1_CT);
    send(B_PT, B_KEY);
    wait_out(n);
    check("b_lat", 128'(n), 128'(ITER));
    check("b_data", data_out, B_CT);
    bad_v = 0;
    bad_d = 0;
    bad_r = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1) bad_v++;
      if (data_out !== B_CT) bad_d++;
      if (in_ready !== 1'b0) bad_r++;
    end
    check("b_stall_valid", 128'(bad_v), 128'(0));
    check("b_stall_data", 128'(bad_d), 128'(0));
    check("b_stall_ready", 128'(bad_r), 128'(0));
    release_out();
    data_in = '0;
    key = '0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 3; k++) t[k] = 0;
    for (int e = 1; e <= 100 && cnt < 3; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        check($sformatf("b2b_data%0d", cnt), data_out, Z_CT);
        t[cnt] = e;
        cnt++;
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b_count", 128'(cnt), 128'(3));
    check("b2b_first", 128'(t[0]), 128'(ITER + 1));
    check("b2b_gap1", 128'(t[1] - t[0]), 128'(ITER + 2));
    check("b2b_gap2", 128'(t[2] - t[1]), 128'(ITER + 2));
    send(C1_PT, C1_KEY);
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    n = 4;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("en_lat", 128'(n), 128'(ITER + 3));
    check("en_data", data_out, C1_CT);
    release_out();
    send(B_PT, B_KEY);
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    check("clr_valid", 128'(out_valid), 128'(0));
    check("clr_data", data_out, 128'(0));
    #2;
    clr = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("clr_no_out", 128'(seen), 128'(0));
    check("clr_ready", 128'(in_ready), 128'(1));
    send(B_PT, B_KEY);
    wait_out(n);
    check("clr_next_lat", 128'(n), 128'(ITER));
    check("clr_next_data", data_out, B_CT);
    release_out();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
Parametrised AES-128 encryption core that generalises the fixed-depth pipelined AES block into an iterative engine. It computes a configurable number of cipher rounds per clock (ROUNDS_PER_CYCLE) and expands round keys on the fly. It adds valid/ready handshakes on both sides, a clock enable and an abort-on-reset guarantee. It sits between the block-level data mover and the output buffer of the crypto datapath.

Parameters:
ROUNDS_PER_CYCLE, 1, rounds computed per busy cycle; legal values 1, 2, 5, 10; any other value is a compile-time error
ITER, 10/ROUNDS_PER_CYCLE, derived localparam: number of busy cycles per block

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-high reset
en  input  1  clock enable; when low, all registers hold (handshakes frozen)
in_valid  input  1  data_in/key valid
in_ready  output  1  core can accept a block
data_in  input  128  plaintext, bit 127 = byte 0 (FIPS-197 order)
key  input  128  cipher key, same byte order
out_valid  output  1  data_out holds a finished ciphertext
out_ready  input  1  consumer accepts data_out
data_out  output  128  ciphertext, same byte order

Behaviour:
- Reset (clr=1, asynchronous): FSM=IDLE, state/roundkey/round counter = 0, data_out=0, out_valid=0, in_ready=1 once clr deasserts. Reset mid-operation aborts the block silently; no out_valid is ever produced for it.
- All transitions below require en=1. With en=0, everything holds, including out_valid/data_out.
- FSM IDLE:
  - in_ready=1.
  - on in_valid: latch state <= data_in ^ key, roundkey <= key, rnd <= 1; go to BUSY.
- FSM BUSY:
  - in_ready=0.
  - each cycle applies ROUNDS_PER_CYCLE consecutive rounds rnd..rnd+R-1 as a combinational chain: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
  - each round's key is derived in the chain from the previous round key with rcon(rnd).
  - round 10 skips MixColumns.
  - registers state, last roundkey, rnd += R.
  - after ITER cycles, go to DONE.
- FSM DONE:
  - out_valid=1, data_out = final state.
  - on out_ready: out_valid drops next edge, go to IDLE.
  - data_out holds its value after the handshake until the next block completes.
- Latency: accept edge T, out_valid high after edge T+ITER. Minimum issue interval is ITER+2 cycles. in_ready is never high while out_valid is high.
- in_valid while not in_ready is ignored; the source must hold data until accepted.
- out_ready while out_valid=0 has no effect.
- S-box is a composite-field GF((2^4)^2) function. There are no table ROMs. All 16 S-boxes per round plus 4 key-schedule S-boxes are instantiated per unrolled round.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36, indexed by absolute round number.

Optional Feature:
Macro AES_CTR_MODE_EN.
- Defined:
  - adds ports iv (input 128) and iv_load (input 1).
  - iv_load in IDLE (priority over in_valid) loads an internal counter ctr <= iv.
  - on each accepted block, the core encrypts ctr instead of data_in.
  - it stores data_in in a 128-bit side register.
  - data_out = keystream ^ stored data_in.
  - ctr increments by 1 modulo 2^128 per accepted block; wrap from all-ones goes to 0.
  - clr clears ctr to 0.
- Undefined: plain ECB encryption as above; iv/iv_load ports absent.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid rises exactly ITER edges after accept. Run for each ROUNDS_PER_CYCLE in {1,2,5,10}.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Then, with out_ready held low for 20 cycles, out_valid and data_out stay stable and in_ready stays 0.
- Back-to-back stream: in_valid and out_ready both held high with zero key and zero data -> every block yields 66e94bd4ef8a2c3b884cfa59ca342b2e, one block per ITER+2 cycles.
- en toggled low for 3 cycles mid-BUSY -> same ciphertext, latency extended by exactly 3 cycles.
- clr pulsed mid-BUSY, in a cycle not aligned to clk -> outputs 0 immediately, no out_valid. The next block after reset is correct.
- AES_CTR_MODE_EN: iv = ffffffffffffffffffffffffffffffff, two blocks of data_in = 0 -> outputs are E(key, all-ones) and then E(key, 0). The second output matches the zero-counter encryption, which checks the counter wrap.
